// File: rtl/add_sub_pkg.sv
// Shared definitions for the add/subtract sequencer: state encoding, width helpers.
package add_sub_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   typedef enum logic [1:0] {
      StIdle = IDLE,
      StRun  = RUN,
      StDone = DONE
   } state_e;

   // Total operand width for a given slice width and slice count.
   function automatic int unsigned op_width(input int unsigned n, input int unsigned words);
      return n * words;
   endfunction

   // Slice index width; never below one bit so WORDS=1 still has a register.
   function automatic int unsigned idx_width(input int unsigned words);
      return (words <= 1) ? 1 : $clog2(words);
   endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational N-bit ripple adder slice shared across all slices of an operation.
module add_slice #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         c_in,
   output logic [N-1:0] sum,
   output logic         c_out
);

   logic [N:0] full;

   assign full  = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};
   assign sum   = full[N-1:0];
   assign c_out = full[N];

endmodule

// File: rtl/add_sub_sequencer.sv
// Wide add/subtract built from one shared N-bit slice, LSB slice first, carry registered
// between slices. Optional signed-overflow output enabled by ADD_SUB_OVF_DETECT_EN.
module add_sub_sequencer
   import add_sub_pkg::*;
#(
   parameter int unsigned N     = 4,
   parameter int unsigned WORDS = 4,
   localparam int unsigned W    = op_width(N, WORDS)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         sub,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         c_out
`ifdef ADD_SUB_OVF_DETECT_EN
   ,
   output logic         ovf
`endif
);

   localparam int unsigned IW = idx_width(WORDS);
   localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

   state_e state_q, state_d;

   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic          carry_q, carry_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [W-1:0]  result_q, result_d;
   logic          c_out_q, c_out_d;

   logic [N-1:0]  slice_a;
   logic [N-1:0]  slice_b;
   logic [N-1:0]  slice_sum;
   logic          slice_cout;
   logic          last_slice;

   assign slice_a    = a_q[idx_q*N +: N];
   assign slice_b    = b_q[idx_q*N +: N];
   assign last_slice = (idx_q == LAST_IDX);

   add_slice #(
      .N (N)
   ) u_slice (
      .a     (slice_a),
      .b     (slice_b),
      .c_in  (carry_q),
      .sum   (slice_sum),
      .c_out (slice_cout)
   );

`ifdef ADD_SUB_OVF_DETECT_EN
   logic ovf_q, ovf_d;
   logic msb_cin;

   // Carry into the slice MSB recovered from its sum bit.
   assign msb_cin = slice_a[N-1] ^ slice_b[N-1] ^ slice_sum[N-1];
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (start) state_d = StRun;
         StRun:   if (last_slice) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Status outputs decoded from state.
   always_comb begin
      busy = (state_q != StIdle);
      done = (state_q == StDone);
   end

   // Datapath next values: latch on accept, one slice per RUN cycle.
   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      carry_d  = carry_q;
      idx_d    = idx_q;
      result_d = result_q;
      c_out_d  = c_out_q;
`ifdef ADD_SUB_OVF_DETECT_EN
      ovf_d    = ovf_q;
`endif
      case (state_q)
         StIdle: begin
            if (start) begin
               a_d     = a;
               // Subtract as a + ~b + 1: invert b here, the +1 is the initial carry.
               b_d     = sub ? ~b : b;
               carry_d = sub;
               idx_d   = '0;
            end
         end
         StRun: begin
            result_d[idx_q*N +: N] = slice_sum;
            carry_d                = slice_cout;
            idx_d                  = idx_q + IW'(1);
            if (last_slice) begin
               c_out_d = slice_cout;
`ifdef ADD_SUB_OVF_DETECT_EN
               ovf_d   = msb_cin ^ slice_cout;
`endif
            end
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         carry_q  <= 1'b0;
         idx_q    <= '0;
         result_q <= '0;
         c_out_q  <= 1'b0;
`ifdef ADD_SUB_OVF_DETECT_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         carry_q  <= carry_d;
         idx_q    <= idx_d;
         result_q <= result_d;
         c_out_q  <= c_out_d;
`ifdef ADD_SUB_OVF_DETECT_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign result = result_q;
   assign c_out  = c_out_q;
`ifdef ADD_SUB_OVF_DETECT_EN
   assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_add_sub_sequencer.sv
// Directed bench for add_sub_sequencer (N=4, WORDS=4). Checks ovf when
// ADD_SUB_OVF_DETECT_EN is defined.
module tb_add_sub_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        sub;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        c_out;
`ifdef ADD_SUB_OVF_DETECT_EN
   logic        ovf;
`endif

   int n_vec = 0;
   int n_err = 0;

   add_sub_sequencer #(
      .N     (4),
      .WORDS (4)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .sub    (sub),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .c_out  (c_out)
`ifdef ADD_SUB_OVF_DETECT_EN
      ,
      .ovf    (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, want finish before 200000");
      $fatal(1, "timeout");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge in IDLE; returns at the negedge after the done cycle (IDLE again).
   task automatic run_op(input string tag, input logic [15:0] op_a, input logic [15:0] op_b,
                         input logic op_sub, input logic [15:0] exp_res, input logic exp_c,
                         input logic exp_ovf);
      int cyc;
      start = 1'b1;
      a     = op_a;
      b     = op_b;
      sub   = op_sub;
      @(negedge clk);
      start = 1'b0;
      // Scramble inputs during RUN; they must not matter.
      a     = 16'hDEAD;
      b     = 16'hBEEF;
      sub   = ~op_sub;
      check_eq({tag, "/busy"}, 32'(busy), 32'd1);
      cyc = 0;
      while (!done && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check_eq({tag, "/latency"}, 32'(cyc), 32'd4);
      check_eq({tag, "/result"}, 32'(result), 32'(exp_res));
      check_eq({tag, "/c_out"}, 32'(c_out), 32'(exp_c));
`ifdef ADD_SUB_OVF_DETECT_EN
      check_eq({tag, "/ovf"}, 32'(ovf), 32'(exp_ovf));
`else
      if (exp_ovf === 1'bx) $display("note: unexpected x");
`endif
      @(negedge clk);
      check_eq({tag, "/done_low"}, 32'(done), 32'd0);
      check_eq({tag, "/idle"}, 32'(busy), 32'd0);
      check_eq({tag, "/held"}, 32'(result), 32'(exp_res));
   endtask

   initial begin
      int pulses;
      logic [15:0] res_at_done;
      logic done_seen;

      rst_n = 1'b0;
      start = 1'b0;
      sub   = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge clk);
      check_eq("rst/busy", 32'(busy), 32'd0);
      check_eq("rst/done", 32'(done), 32'd0);
      check_eq("rst/result", 32'(result), 32'd0);
      check_eq("rst/c_out", 32'(c_out), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op("add_basic", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
      run_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      // Next start issued in the first cycle IDLE is reachable again.
      run_op("sub_pos", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);

      // Start pulsed again during RUN must be ignored.
      start = 1'b1;
      a     = 16'h0001;
      b     = 16'h0001;
      sub   = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      a     = 16'hAAAA;
      b     = 16'h5555;
      @(negedge clk);
      start = 1'b0;
      pulses      = 0;
      res_at_done = 16'h0;
      repeat (12) begin
         @(negedge clk);
         if (done) begin
            pulses++;
            res_at_done = result;
         end
      end
      check_eq("ign/pulses", 32'(pulses), 32'd1);
      check_eq("ign/result_at_done", 32'(res_at_done), 32'h0002);
      check_eq("ign/result_held", 32'(result), 32'h0002);
      check_eq("ign/idle", 32'(busy), 32'd0);

      // Reset after two RUN edges aborts with no done pulse.
      start = 1'b1;
      a     = 16'h1111;
      b     = 16'h1111;
      sub   = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("mid/partial", 32'(result), 32'h0022);
      check_eq("mid/busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("abort/busy", 32'(busy), 32'd0);
      check_eq("abort/done", 32'(done), 32'd0);
      check_eq("abort/result", 32'(result), 32'd0);
      check_eq("abort/c_out", 32'(c_out), 32'd0);
      done_seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         done_seen = done_seen | done;
      end
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         done_seen = done_seen | done;
      end
      check_eq("abort/no_done", 32'(done_seen), 32'd0);
      check_eq("abort/idle", 32'(busy), 32'd0);
      run_op("post_rst", 16'h0100, 16'h0100, 1'b0, 16'h0200, 1'b0, 1'b0);

      run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_op("ovf_sub", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
